any1_memseq: RTL

- Memory access sequencer; consumes the registered effective address and access descriptor for ANY-1 scalar load/store instructions.
- Runs one or two bus cycles on the 64-bit data bus.
- Splits accesses that cross an 8-byte boundary; aligns store data and byte selects.
- Realigns and sign/zero-extends load data; returns the result and completion to the pipeline.

---
 rtl/any1_memseq.sv | 126 ++++++++++++
 1 files changed

// File: rtl/any1_memseq.sv
// any1_memseq: ANY-1 load/store bus sequencer with split, align and extend; optional ANY1_MEMSEQ_TIMEOUT_EN bus timeout
module any1_memseq #(
  parameter int AWID = 32,
  parameter int TMO_CYCLES = 255
) (
  input  logic            rst,
  input  logic            clk,
  input  logic            req,
  output logic            rdy,
  input  logic            we,
  input  logic [1:0]      size,
  input  logic            zx,
  input  logic [AWID-1:0] ea,
  input  logic [63:0]     st_data,
  output logic            done,
  output logic [63:0]     ld_data,
  output logic            err,
  output logic            cyc_o,
  output logic            stb_o,
  output logic            we_o,
  output logic [7:0]      sel_o,
  output logic [AWID-1:0] adr_o,
  output logic [63:0]     dat_o,
  input  logic            ack_i,
  input  logic            err_i,
  input  logic [63:0]     dat_i
);
  typedef enum logic [2:0] {IDLE, ACC1, GAP, ACC2, FIN} state_t;
  state_t state_q, state_d;
  logic we_q, we_d, zx_q, zx_d, rdy_q, rdy_d, cyc_q, cyc_d, bwe_q, bwe_d, done_q, done_d, err_q, err_d;
  logic [1:0] size_q, size_d;
  logic [2:0] off_q, off_d;
  logic [7:0] sel_q, sel_d, sel_hi_q, sel_hi_d, bm;
  logic [AWID-1:0] adr_q, adr_d;
  logic [63:0] dat_q, dat_d, dat_hi_q, dat_hi_d, lo_q, lo_d, ld_q, ld_d, wm;
  logic [15:0] m;
  logic [127:0] d;
  logic tmo_hit;
  assign rdy     = rdy_q;
  assign done    = done_q;
  assign err     = err_q;
  assign ld_data = ld_q;
  assign cyc_o   = cyc_q;
  assign stb_o   = cyc_q;
  assign we_o    = bwe_q;
  assign sel_o   = sel_q;
  assign adr_o   = adr_q;
  assign dat_o   = dat_q;
  // Shift the raw two-beat window down to the access offset, then sign- or zero-extend from the access width
  function automatic logic [63:0] extend(input logic [127:0] raw, input logic [2:0] off, input logic [1:0] sz, input logic z);
    logic [63:0] r;
    r = 64'(raw >> {off, 3'b000});
    return sz == 2'd0 ? {{56{~z & r[7]}}, r[7:0]} :
           sz == 2'd1 ? {{48{~z & r[15]}}, r[15:0]} :
           sz == 2'd2 ? {{32{~z & r[31]}}, r[31:0]} : r;
  endfunction
  // Byte-lane mask and store data for the incoming request, spanning two 8-byte beats
  always_comb begin
    bm = size == 2'd0 ? 8'h01 : size == 2'd1 ? 8'h03 : size == 2'd2 ? 8'h0F : 8'hFF;
    wm = (64'd1 << (7'd8 << size)) - 64'd1;
    m  = {8'h00, bm} << ea[2:0];
    d  = {64'h0, st_data & wm} << {ea[2:0], 3'b000};
  end
`ifdef ANY1_MEMSEQ_TIMEOUT_EN
  logic [31:0] tmo_q, tmo_d;
  logic in_acc;
  // Count stalled bus cycles; outside an access the counter sits at zero so every entry starts fresh
  always_comb begin
    in_acc  = state_q == ACC1 || state_q == ACC2;
    tmo_d   = in_acc && !ack_i && !err_i ? tmo_q + 32'd1 : 32'd0;
    tmo_hit = in_acc && !ack_i && !err_i && tmo_q == 32'(TMO_CYCLES - 1);
  end
  // Timeout counter register
  always_ff @(posedge clk or posedge rst)
    if (rst) tmo_q <= 32'd0;
    else tmo_q <= tmo_d;
`else
  if (TMO_CYCLES < 1) begin : g_tmo_unused
  end
  assign tmo_hit = 1'b0;
`endif
  // Sequencer next state and next registered bus/pipeline outputs
  always_comb begin
    state_d = state_q; we_d = we_q; zx_d = zx_q; size_d = size_q; off_d = off_q;
    adr_d = adr_q; sel_d = sel_q; dat_d = dat_q; sel_hi_d = sel_hi_q; dat_hi_d = dat_hi_q;
    lo_d = lo_q; rdy_d = rdy_q; cyc_d = cyc_q; bwe_d = bwe_q; done_d = 1'b0; err_d = err_q; ld_d = ld_q;
    case (state_q)
      IDLE: if (req) begin
        state_d = ACC1; we_d = we; zx_d = zx; size_d = size; off_d = ea[2:0];
        adr_d = {ea[AWID-1:3], 3'b000}; sel_d = m[7:0]; dat_d = d[63:0];
        sel_hi_d = m[15:8]; dat_hi_d = d[127:64];
        rdy_d = 1'b0; cyc_d = 1'b1; bwe_d = we; err_d = 1'b0;
      end
      ACC1, ACC2: if (err_i || tmo_hit) begin
        state_d = FIN; done_d = 1'b1; err_d = 1'b1; cyc_d = 1'b0; bwe_d = 1'b0; sel_d = 8'h00;
      end else if (ack_i) begin
        cyc_d = 1'b0; bwe_d = 1'b0; sel_d = 8'h00;
        if (state_q == ACC1 && sel_hi_q != 8'h00) begin
          state_d = GAP; lo_d = dat_i;
        end else begin
          state_d = FIN; done_d = 1'b1;
          ld_d = we_q ? ld_q : extend(state_q == ACC1 ? {64'h0, dat_i} : {dat_i, lo_q}, off_q, size_q, zx_q);
        end
      end
      GAP: begin
        state_d = ACC2; adr_d = adr_q + AWID'(8); sel_d = sel_hi_q; dat_d = dat_hi_q;
        cyc_d = 1'b1; bwe_d = we_q;
      end
      FIN: begin
        state_d = IDLE; rdy_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  // State and output registers; reset drops any bus cycle in flight
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE; we_q <= 1'b0; zx_q <= 1'b0; size_q <= 2'd0; off_q <= 3'd0;
      adr_q <= '0; sel_q <= 8'h00; dat_q <= 64'h0; sel_hi_q <= 8'h00; dat_hi_q <= 64'h0;
      lo_q <= 64'h0; rdy_q <= 1'b1; cyc_q <= 1'b0; bwe_q <= 1'b0; done_q <= 1'b0; err_q <= 1'b0; ld_q <= 64'h0;
    end else begin
      state_q <= state_d; we_q <= we_d; zx_q <= zx_d; size_q <= size_d; off_q <= off_d;
      adr_q <= adr_d; sel_q <= sel_d; dat_q <= dat_d; sel_hi_q <= sel_hi_d; dat_hi_q <= dat_hi_d;
      lo_q <= lo_d; rdy_q <= rdy_d; cyc_q <= cyc_d; bwe_q <= bwe_d; done_q <= done_d; err_q <= err_d; ld_q <= ld_d;
    end
endmodule
